// File: rtl/clk_div_pkg.sv
// Shared types and constants for the multi-channel clock divider.
package clk_div_pkg;

   // Output shape per channel: square-ish clock or single-cycle strobe
   typedef enum logic {
      MODE_HALF  = 1'b0,
      MODE_PULSE = 1'b1
   } mode_e;

   // Smallest usable divisor; written values below this saturate up to it
   localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active/pending divisor, registered outputs.
// Ports:
//   clk, rst_n              - system clock, synchronous active-low reset
//   en                      - channel run enable
//   mode                    - requested output mode, latched at each period start
//   div_we, div_wdata       - divisor write into the pending register
//   sync                    - restart the period now (enabled channels only)
//   clk_div, tick, busy     - divided output, period-start pulse, write pending
module clk_div_chan
   import clk_div_pkg::*;
#(
   parameter int unsigned DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  mode_e            mode,
   input  logic             div_we,
   input  logic [DIV_W-1:0] div_wdata,
   input  logic             sync,
   output logic             clk_div,
   output logic             tick,
   output logic             busy
);

   logic [DIV_W-1:0] cnt,        cnt_nxt;
   logic [DIV_W-1:0] active_div, active_nxt;
   logic [DIV_W-1:0] pend_div,   pend_nxt;
   logic             running,    running_nxt;
   logic             busy_nxt;
   logic             clk_div_nxt;
   logic             tick_nxt;
   mode_e            mode_act,   mode_nxt;

   logic             period_start;
   logic [DIV_W-1:0] wr_sat;

   // Next-state: period tracking, divisor hand-over and output shaping
   always_comb begin
      cnt_nxt      = cnt;
      active_nxt   = active_div;
      pend_nxt     = pend_div;
      running_nxt  = running;
      busy_nxt     = busy;
      mode_nxt     = mode_act;
      clk_div_nxt  = 1'b0;
      tick_nxt     = 1'b0;
      period_start = 1'b0;
      wr_sat       = (div_wdata < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div_wdata;

      if (!en) begin
         cnt_nxt     = '0;
         running_nxt = 1'b0;
      end else begin
         period_start = !running || sync || (cnt == active_div - DIV_W'(1));
         running_nxt  = 1'b1;
         if (period_start) begin
            // A pending divisor written on an earlier edge takes over here
            if (busy) begin
               active_nxt = pend_div;
               busy_nxt   = 1'b0;
            end
            mode_nxt    = mode;
            cnt_nxt     = '0;
            tick_nxt    = 1'b1;
            // cnt = 0 is high in both modes since floor(D/2) >= 1
            clk_div_nxt = 1'b1;
         end else begin
            cnt_nxt     = cnt + DIV_W'(1);
            clk_div_nxt = (mode_act == MODE_HALF) && (cnt_nxt < (active_div >> 1));
         end
      end

      // A write on a boundary edge stays pending for the following period
      if (div_we) begin
         pend_nxt = wr_sat;
         busy_nxt = 1'b1;
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt        <= '0;
         active_div <= DIV_W'(MIN_DIV);
         pend_div   <= '0;
         running    <= 1'b0;
         busy       <= 1'b0;
         mode_act   <= MODE_HALF;
         clk_div    <= 1'b0;
         tick       <= 1'b0;
      end else begin
         cnt        <= cnt_nxt;
         active_div <= active_nxt;
         pend_div   <= pend_nxt;
         running    <= running_nxt;
         busy       <= busy_nxt;
         mode_act   <= mode_nxt;
         clk_div    <= clk_div_nxt;
         tick       <= tick_nxt;
      end
   end

endmodule

// File: rtl/clk_divider_multi.sv
// Multi-channel programmable clock divider; fans shared controls out to N_CH channels.
// Ports:
//   clk, rst_n          - system clock, synchronous active-low reset
//   en, mode            - per-channel enable and mode (0 half, 1 pulse)
//   div_we, div_wdata   - per-channel write strobes, shared divisor value
//   sync                - global phase-align request
//   clk_div, tick, busy - per-channel divided output, period start, write pending
module clk_divider_multi
   import clk_div_pkg::*;
#(
   parameter int unsigned N_CH  = 4,
   parameter int unsigned DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_CH-1:0]  en,
   input  logic [N_CH-1:0]  mode,
   input  logic [N_CH-1:0]  div_we,
   input  logic [DIV_W-1:0] div_wdata,
   input  logic             sync,
   output logic [N_CH-1:0]  clk_div,
   output logic [N_CH-1:0]  tick,
   output logic [N_CH-1:0]  busy
);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      clk_div_chan #(
         .DIV_W (DIV_W)
      ) u_chan (
         .clk       (clk),
         .rst_n     (rst_n),
         .en        (en[i]),
         .mode      (mode_e'(mode[i])),
         .div_we    (div_we[i]),
         .div_wdata (div_wdata),
         .sync      (sync),
         .clk_div   (clk_div[i]),
         .tick      (tick[i]),
         .busy      (busy[i])
      );
   end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Self-checking bench: directed scenarios plus random traffic against a period-level model.
module tb_clk_divider_multi;

   localparam int unsigned N_CH  = 4;
   localparam int unsigned DIV_W = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [N_CH-1:0]  en;
   logic [N_CH-1:0]  mode;
   logic [N_CH-1:0]  div_we;
   logic [DIV_W-1:0] div_wdata;
   logic             sync;
   logic [N_CH-1:0]  clk_div;
   logic [N_CH-1:0]  tick;
   logic [N_CH-1:0]  busy;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: position within the current period, period length, pending divisor
   int m_run   [N_CH];
   int m_pos   [N_CH];
   int m_len   [N_CH];
   int m_mode  [N_CH];
   int m_pendv [N_CH];
   int m_pend  [N_CH];
   logic [N_CH-1:0] e_clk, e_tick, e_busy;

   clk_divider_multi #(.N_CH(N_CH), .DIV_W(DIV_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .mode      (mode),
      .div_we    (div_we),
      .div_wdata (div_wdata),
      .sync      (sync),
      .clk_div   (clk_div),
      .tick      (tick),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Advance the model by one clock using the inputs currently applied
   task automatic model_edge();
      int w;
      w = (int'(div_wdata) < 2) ? 2 : int'(div_wdata);
      for (int c = 0; c < N_CH; c++) begin
         if (!rst_n) begin
            m_run[c] = 0; m_pos[c] = 0; m_len[c] = 2; m_mode[c] = 0;
            m_pendv[c] = 0; m_pend[c] = 0;
            e_clk[c] = 1'b0; e_tick[c] = 1'b0;
         end else begin
            if (!en[c]) begin
               m_run[c] = 0; m_pos[c] = 0;
               e_clk[c] = 1'b0; e_tick[c] = 1'b0;
            end else begin
               if (m_run[c] == 0 || sync || m_pos[c] == m_len[c] - 1) begin
                  if (m_pendv[c] != 0) begin
                     m_len[c]   = m_pend[c];
                     m_pendv[c] = 0;
                  end
                  m_mode[c] = int'(mode[c]);
                  m_pos[c]  = 0;
               end else begin
                  m_pos[c]++;
               end
               m_run[c]  = 1;
               e_tick[c] = (m_pos[c] == 0);
               e_clk[c]  = (m_mode[c] == 1) ? (m_pos[c] == 0) : (m_pos[c] < m_len[c] / 2);
            end
            if (div_we[c]) begin
               m_pend[c]  = w;
               m_pendv[c] = 1;
            end
         end
         e_busy[c] = (m_pendv[c] != 0);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("clk_div", int'(clk_div), int'(e_clk));
      check("tick",    int'(tick),    int'(e_tick));
      check("busy",    int'(busy),    int'(e_busy));
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic write(input logic [N_CH-1:0] mask, input int val);
      div_we    = mask;
      div_wdata = DIV_W'(val);
      step();
      div_we    = '0;
   endtask

   initial begin
      logic [9:0] pat;
      rst_n = 1'b0; en = '0; mode = '0; div_we = '0; div_wdata = '0; sync = 1'b0;

      // Reset state
      run(3);
      check("rst_clk",  int'(clk_div), 0);
      check("rst_tick", int'(tick),    0);
      check("rst_busy", int'(busy),    0);

      // D = 5 half mode on channel 0: 1,1,0,0,0 with tick on the first enabled edge
      rst_n = 1'b1;
      write(4'b0001, 5);
      check("pend_busy", int'(busy[0]), 1);
      en = 4'b0001;
      pat = 10'b0001100011; // bit k = expected clk_div on the k-th enabled edge
      for (int k = 0; k < 10; k++) begin
         step();
         check("d5_clk",  int'(clk_div[0]), int'(pat[k]));
         check("d5_tick", int'(tick[0]),    (k % 5 == 0) ? 1 : 0);
      end

      // Writes of 0 then 1 saturate to D = 2
      write(4'b0001, 0);
      write(4'b0001, 1);
      run(12);

      // D = 6, then write 3 mid-period
      write(4'b0001, 6);
      run(9);
      write(4'b0001, 3);
      run(12);

      // Two channels D = 4 and D = 7, sync mid-period
      en = '0;
      write(4'b0001, 4);
      write(4'b0010, 7);
      en = 4'b0011;
      run(10);
      sync = 1'b1;
      step();
      check("sync_tick", int'(tick[1:0]), 3);
      sync = 1'b0;
      run(20);

      // Pulse mode D = 15 on channel 2
      mode = 4'b0100;
      write(4'b0100, 15);
      en = 4'b0111;
      run(35);

      // Disable and reset mid high phase, then re-enable
      mode = '0;
      write(4'b0001, 8);
      run(10);
      en[0] = 1'b0;
      step();
      check("dis_clk", int'(clk_div[0]), 0);
      en[0] = 1'b1;
      run(6);
      rst_n = 1'b0;
      step();
      check("rst_mid_clk", int'(clk_div), 0);
      rst_n = 1'b1;
      run(10);

      // Random traffic including boundary collisions, syncs and resets
      for (int k = 0; k < 4000; k++) begin
         rst_n = ($urandom_range(0, 299) != 0);
         sync  = ($urandom_range(0, 59) == 0);
         for (int c = 0; c < N_CH; c++) begin
            if ($urandom_range(0, 39) == 0) en[c]   = ~en[c];
            if ($urandom_range(0, 29) == 0) mode[c] = ~mode[c];
            div_we[c] = ($urandom_range(0, 24) == 0);
         end
         div_wdata = ($urandom_range(0, 19) == 0) ? DIV_W'($urandom_range(0, 255))
                                                  : DIV_W'($urandom_range(0, 12));
         step();
      end
      div_we = '0;
      sync   = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
